// File: rtl/cla_sum_tx.sv
// ---------------------------------------------------------------------------
// cla_sum_tx
//
// Serial transmitter for the 4-bit carry-lookahead adder result. One result
// ({COUT, SUM}) is taken over a valid/ready handshake and sent on a single
// wire as a framed, LSB-first bit stream:
//     start(0), DATA_W data bits, optional even parity, stop(1)
// Each line bit is held for BIT_CYCLES clock cycles. The line idles high.
//
// Parameters
//   DATA_W      frame payload width (payload is {COUT, SUM})
//   BIT_CYCLES  clock cycles per line bit (>= 1)
//   PARITY_EN   1 = insert an even-parity bit after the data, 0 = omit it
//
// Ports
//   CLK         clock, rising edge active
//   RST         asynchronous, active-low reset
//   LOAD_VALID  a result is presented on SUM/COUT
//   LOAD_READY  high exactly while idle; an accept happens on a rising edge
//               with LOAD_VALID and LOAD_READY both high
//   SUM, COUT   adder result, sampled only at the accepting edge
//   TX_OUT      registered serial line
//   TX_BUSY     a frame is in progress
//   DONE        one-cycle pulse in the first idle cycle after a stop bit
// ---------------------------------------------------------------------------
module cla_sum_tx #(
    parameter int DATA_W     = 5,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOAD_VALID,
    output logic       LOAD_READY,
    input  logic [3:0] SUM,
    input  logic       COUT,
    output logic       TX_OUT,
    output logic       TX_BUSY,
    output logic       DONE
);

    // Counters are kept at least one bit wide so that BIT_CYCLES = 1 still
    // gives a legal vector; with one cycle per bit the counter just stays 0.
    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state;
    logic [CYC_W-1:0]    cyc_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift_reg;
    logic                parity_bit;
    logic                tx_reg;
    logic                done_reg;

    logic [DATA_W-1:0]   payload;
    logic [DATA_W-1:0]   shift_next;
    logic                bit_end;

    // Payload ordering puts SUM[0] first on the line and COUT last.
    assign payload    = DATA_W'({COUT, SUM});
    // The value the shift register holds once the current data bit retires;
    // its LSB is the next data bit to put on the line.
    assign shift_next = shift_reg >> 1;
    // Last cycle of the current line bit.
    assign bit_end    = (cyc_cnt == CYC_LAST);

    // Frame sequencer. The line register is loaded with the level of the
    // state being entered, so TX_OUT changes on the same edge as the state
    // and never glitches. DONE defaults low each cycle and is raised only on
    // the edge that returns from STOP to IDLE, giving a single-cycle pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_reg     <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (LOAD_VALID) begin
                        shift_reg  <= payload;
                        parity_bit <= ^payload;
                        cyc_cnt    <= '0;
                        bit_cnt    <= '0;
                        state      <= START;
                        tx_reg     <= 1'b0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        state   <= DATA;
                        tx_reg  <= shift_reg[0];
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state  <= PARITY;
                                tx_reg <= parity_bit;
                            end else begin
                                state  <= STOP;
                                tx_reg <= 1'b1;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= shift_next;
                            tx_reg    <= shift_next[0];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        state   <= STOP;
                        tx_reg  <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                STOP: begin
                    tx_reg <= 1'b1;
                    if (bit_end) begin
                        cyc_cnt  <= '0;
                        state    <= IDLE;
                        done_reg <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    cyc_cnt <= '0;
                    bit_cnt <= '0;
                    tx_reg  <= 1'b1;
                end
            endcase
        end
    end

    // Handshake and status are decoded straight from the state register so
    // they follow reset immediately and agree with the state on every cycle.
    assign LOAD_READY = (state == IDLE);
    assign TX_BUSY    = (state != IDLE);
    assign TX_OUT     = tx_reg;
    assign DONE       = done_reg;

endmodule

// File: tb/tb_cla_sum_tx.sv
// ---------------------------------------------------------------------------
// tb_cla_sum_tx
//
// Self-checking bench for cla_sum_tx. Two instances share the clock and
// reset: dut uses the default parameters, dut_fast uses BIT_CYCLES = 1 and
// no parity. Expected line levels come from a frame model that works out
// which frame bit a cycle offset falls in and what that bit must be.
// ---------------------------------------------------------------------------
module tb_cla_sum_tx;

    localparam int BC   = 4;
    localparam int PEN  = 1;
    localparam int F    = (7 + PEN) * BC;
    localparam int BC2  = 1;
    localparam int PEN2 = 0;
    localparam int F2   = (7 + PEN2) * BC2;

    logic       clk;
    logic       rst_n;

    logic       load_valid;
    logic       load_ready;
    logic [3:0] sum;
    logic       cout;
    logic       tx_out;
    logic       tx_busy;
    logic       done;

    logic       load_valid2;
    logic       load_ready2;
    logic [3:0] sum2;
    logic       cout2;
    logic       tx_out2;
    logic       tx_busy2;
    logic       done2;

    int n_checks;
    int n_fail;

    cla_sum_tx #(.DATA_W(5), .BIT_CYCLES(BC), .PARITY_EN(PEN)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .LOAD_VALID (load_valid),
        .LOAD_READY (load_ready),
        .SUM        (sum),
        .COUT       (cout),
        .TX_OUT     (tx_out),
        .TX_BUSY    (tx_busy),
        .DONE       (done)
    );

    cla_sum_tx #(.DATA_W(5), .BIT_CYCLES(BC2), .PARITY_EN(PEN2)) dut_fast (
        .CLK        (clk),
        .RST        (rst_n),
        .LOAD_VALID (load_valid2),
        .LOAD_READY (load_ready2),
        .SUM        (sum2),
        .COUT       (cout2),
        .TX_OUT     (tx_out2),
        .TX_BUSY    (tx_busy2),
        .DONE       (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level j cycles after the accepting edge for payload p:
    // frame bit n = j / bc; bit 0 is start, 1..5 payload LSB first, then
    // parity (if enabled) and finally the stop bit.
    function automatic logic model_line(input logic [4:0] p, input int j,
                                        input int bc, input int pen);
        int n;
        n = j / bc;
        if (n == 0) return 1'b0;
        if (n <= 5) return p[n-1];
        if (pen != 0 && n == 6) return ^p;
        return 1'b1;
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        load_valid  = 1'b0;
        load_valid2 = 1'b0;
        sum = 4'h0; cout = 1'b0; sum2 = 4'h0; cout2 = 1'b0;
        step();
        step();
        n_checks++;
        if ({tx_out, tx_busy, done, load_ready} !== 4'b1001) begin
            n_fail++;
            $display("[TB] FAIL reset_hold {tx,busy,done,ready} got %b want 1001",
                     {tx_out, tx_busy, done, load_ready});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({tx_out, tx_busy, done, load_ready} !== 4'b1001) begin
                n_fail++;
                $display("[TB] FAIL reset_idle[%0d] {tx,busy,done,ready} got %b want 1001",
                         i, {tx_out, tx_busy, done, load_ready});
            end
            n_checks++;
            if ({tx_out2, tx_busy2, done2, load_ready2} !== 4'b1001) begin
                n_fail++;
                $display("[TB] FAIL reset_idle_fast[%0d] got %b want 1001",
                         i, {tx_out2, tx_busy2, done2, load_ready2});
            end
        end
    endtask

    task automatic test_single_frame();
        logic [4:0] p;
        p = {1'b1, 4'b1011};
        sum = 4'b1011; cout = 1'b1; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int j = 0; j < F; j++) begin
            n_checks++;
            if ({tx_out, tx_busy, load_ready, done} !== {model_line(p, j, BC, PEN), 3'b100}) begin
                n_fail++;
                $display("[TB] FAIL single_frame j=%0d {tx,busy,ready,done} got %b want %b",
                         j, {tx_out, tx_busy, load_ready, done}, {model_line(p, j, BC, PEN), 3'b100});
            end
            step();
        end
        n_checks++;
        if ({tx_out, tx_busy, load_ready, done} !== 4'b1011) begin
            n_fail++;
            $display("[TB] FAIL single_end {tx,busy,ready,done} got %b want 1011",
                     {tx_out, tx_busy, load_ready, done});
        end
        step();
        n_checks++;
        if ({tx_out, tx_busy, load_ready, done} !== 4'b1010) begin
            n_fail++;
            $display("[TB] FAIL single_after {tx,busy,ready,done} got %b want 1010",
                     {tx_out, tx_busy, load_ready, done});
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] p1;
        logic [4:0] p2;
        p1 = {1'b0, 4'h3};
        p2 = {1'b1, 4'hC};
        sum = 4'h3; cout = 1'b0; load_valid = 1'b1;
        step();
        sum = 4'hC; cout = 1'b1;
        for (int j = 0; j < F; j++) begin
            n_checks++;
            if ({tx_out, tx_busy, done} !== {model_line(p1, j, BC, PEN), 2'b10}) begin
                n_fail++;
                $display("[TB] FAIL b2b_first j=%0d {tx,busy,done} got %b want %b",
                         j, {tx_out, tx_busy, done}, {model_line(p1, j, BC, PEN), 2'b10});
            end
            step();
        end
        n_checks++;
        if ({tx_out, tx_busy, load_ready, done} !== 4'b1011) begin
            n_fail++;
            $display("[TB] FAIL b2b_gap {tx,busy,ready,done} got %b want 1011",
                     {tx_out, tx_busy, load_ready, done});
        end
        step();
        load_valid = 1'b0;
        for (int j = 0; j < F; j++) begin
            n_checks++;
            if ({tx_out, tx_busy, done} !== {model_line(p2, j, BC, PEN), 2'b10}) begin
                n_fail++;
                $display("[TB] FAIL b2b_second j=%0d {tx,busy,done} got %b want %b",
                         j, {tx_out, tx_busy, done}, {model_line(p2, j, BC, PEN), 2'b10});
            end
            step();
        end
        n_checks++;
        if ({tx_out, tx_busy, done} !== 3'b101) begin
            n_fail++;
            $display("[TB] FAIL b2b_end {tx,busy,done} got %b want 101", {tx_out, tx_busy, done});
        end
        step();
    endtask

    task automatic test_input_change();
        logic [4:0] p;
        p = {1'b0, 4'h5};
        sum = 4'h5; cout = 1'b0; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int j = 0; j < F; j++) begin
            if (j == BC + 1) begin
                sum = 4'hA; cout = 1'b1; load_valid = 1'b1;
            end
            n_checks++;
            if ({tx_out, tx_busy} !== {model_line(p, j, BC, PEN), 1'b1}) begin
                n_fail++;
                $display("[TB] FAIL input_change j=%0d {tx,busy} got %b want %b",
                         j, {tx_out, tx_busy}, {model_line(p, j, BC, PEN), 1'b1});
            end
            step();
        end
        load_valid = 1'b0;
        n_checks++;
        if ({tx_out, done} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL input_change_end {tx,done} got %b want 11", {tx_out, done});
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        logic [4:0] p;
        sum = 4'h9; cout = 1'b1; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        // Advance into data bit 2 (frame bit 3).
        for (int j = 0; j < 3 * BC + 1; j++) step();
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_out, tx_busy, load_ready, done} !== 4'b1010) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_async {tx,busy,ready,done} got %b want 1010",
                     {tx_out, tx_busy, load_ready, done});
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < F; i++) begin
            step();
            n_checks++;
            if ({tx_out, tx_busy, done} !== 3'b100) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_quiet[%0d] {tx,busy,done} got %b want 100",
                         i, {tx_out, tx_busy, done});
            end
        end
        p = 5'($urandom);
        sum = p[3:0]; cout = p[4]; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int j = 0; j < F; j++) begin
            n_checks++;
            if ({tx_out, done} !== {model_line(p, j, BC, PEN), 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_next j=%0d {tx,done} got %b want %b",
                         j, {tx_out, done}, {model_line(p, j, BC, PEN), 1'b0});
            end
            step();
        end
        n_checks++;
        if ({tx_out, done} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_next_end {tx,done} got %b want 11", {tx_out, done});
        end
        step();
    endtask

    task automatic test_random_frames();
        logic [4:0] p;
        for (int f = 0; f < 6; f++) begin
            p = 5'($urandom);
            sum = p[3:0]; cout = p[4]; load_valid = 1'b1;
            step();
            for (int j = 0; j < F; j++) begin
                sum = 4'($urandom); cout = 1'($urandom);
                load_valid = (j < F - 1) ? 1'($urandom) : 1'b0;
                n_checks++;
                if ({tx_out, tx_busy} !== {model_line(p, j, BC, PEN), 1'b1}) begin
                    n_fail++;
                    $display("[TB] FAIL random f=%0d p=%b j=%0d {tx,busy} got %b want %b",
                             f, p, j, {tx_out, tx_busy}, {model_line(p, j, BC, PEN), 1'b1});
                end
                step();
            end
            n_checks++;
            if ({tx_out, tx_busy, done} !== 3'b101) begin
                n_fail++;
                $display("[TB] FAIL random_end f=%0d {tx,busy,done} got %b want 101",
                         f, {tx_out, tx_busy, done});
            end
            step();
        end
    endtask

    task automatic test_param_corner();
        logic [4:0] p;
        p = {1'b0, 4'hF};
        sum2 = 4'hF; cout2 = 1'b0; load_valid2 = 1'b1;
        step();
        sum2 = 4'h0; cout2 = 1'b1;
        for (int j = 0; j < F2; j++) begin
            n_checks++;
            if ({tx_out2, tx_busy2, done2} !== {model_line(p, j, BC2, PEN2), 2'b10}) begin
                n_fail++;
                $display("[TB] FAIL corner j=%0d {tx,busy,done} got %b want %b",
                         j, {tx_out2, tx_busy2, done2}, {model_line(p, j, BC2, PEN2), 2'b10});
            end
            step();
        end
        n_checks++;
        if ({tx_out2, tx_busy2, load_ready2, done2} !== 4'b1011) begin
            n_fail++;
            $display("[TB] FAIL corner_done {tx,busy,ready,done} got %b want 1011",
                     {tx_out2, tx_busy2, load_ready2, done2});
        end
        step();
        load_valid2 = 1'b0;
        n_checks++;
        if ({tx_out2, tx_busy2, load_ready2, done2} !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL corner_reaccept {tx,busy,ready,done} got %b want 0100",
                     {tx_out2, tx_busy2, load_ready2, done2});
        end
        for (int j = 1; j <= F2; j++) step();
        n_checks++;
        if ({tx_out2, done2} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL corner_second_done {tx,done} got %b want 11", {tx_out2, done2});
        end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_input_change();
        test_reset_mid_frame();
        test_random_frames();
        test_param_corner();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
